// File: rtl/alu_iter_if.sv
// Valid/ready bundle between the operand stage, the iterative ALU and writeback.
// The ALU side takes the slave modport; the pipeline or bench side takes the master modport.
interface alu_iter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       Operation;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;

  modport master (
    output in_valid, Operation, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Zero
  );

  modport slave (
    input  in_valid, Operation, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Zero
  );
endinterface

// File: rtl/alu_iter.sv
// Multi-cycle execute unit: single-cycle logic/arith/compare, serial one-bit-per-cycle shifts.
// One op in flight; the result register doubles as the shift register.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  alu_iter_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SRA = 4'b0111,
    OP_EQ  = 4'b1000,
    OP_SLT = 4'b1100
  } op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [3:0]       op_q, op_d;

  logic [WIDTH-1:0] alu_out;
  logic [SHW-1:0]   shamt;
  logic             is_shift;

  assign shamt    = bus.SrcB[SHW-1:0];
  assign is_shift = (bus.Operation == OP_SLL) || (bus.Operation == OP_SRL) ||
                    (bus.Operation == OP_SRA);

  // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_out = '0;
    case (bus.Operation)
      OP_AND:  alu_out = bus.SrcA & bus.SrcB;
      OP_OR:   alu_out = bus.SrcA | bus.SrcB;
      OP_ADD:  alu_out = bus.SrcA + bus.SrcB;
      OP_XOR:  alu_out = bus.SrcA ^ bus.SrcB;
      OP_SUB:  alu_out = bus.SrcA - bus.SrcB;
      OP_EQ:   alu_out = WIDTH'(bus.SrcA == bus.SrcB);
      OP_SLT:  alu_out = WIDTH'($signed(bus.SrcA) < $signed(bus.SrcB));
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    count_d  = count_q;
    op_d     = op_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d = bus.Operation;
          if (is_shift) begin
            result_d = bus.SrcA;
            count_d  = shamt;
            state_d  = (shamt == '0) ? S_DONE : S_SHIFT;
          end else begin
            result_d = alu_out;
            state_d  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        // Only shift codes can reach this state; anything not SLL/SRL is SRA.
        case (op_q)
          OP_SLL:  result_d = {result_q[WIDTH-2:0], 1'b0};
          OP_SRL:  result_d = {1'b0, result_q[WIDTH-1:1]};
          default: result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
        endcase
        count_d = count_q - 1'b1;
        if (count_q == SHW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      count_q  <= '0;
      op_q     <= OP_AND;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      count_q  <= count_d;
      op_q     <= op_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.ALUResult = result_q;
  assign bus.Zero      = (result_q == '0);
endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed vector table, backpressure and reset-mid-shift
// sequences, then randomised back-to-back traffic against a reference model.
module tb_alu_iter;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_iter_if #(.WIDTH(WIDTH)) bus ();

  alu_iter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [4:0] amt;
    amt = b[4:0];
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0100: return a << amt;
      4'b0101: return a >> amt;
      4'b0110: return a - b;
      4'b0111: return $unsigned($signed(a) >>> amt);
      4'b1000: return {31'd0, a == b};
      4'b1100: return {31'd0, $signed(a) < $signed(b)};
      default: return 32'd0;
    endcase
  endfunction

  // Present one op with out_ready high; latency counts clock edges from the accepting edge
  // up to the one after which out_valid is seen.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    int cyc;
    @(negedge clk);
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (!bus.in_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.Operation = ~op;
    bus.SrcA      = ~a;
    bus.SrcB      = ~b;
    while (!bus.out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " result"}, bus.ALUResult, exp);
    check({name, " zero"}, 32'(bus.Zero), 32'(exp == 32'd0));
    check({name, " latency"}, 32'(cyc), 32'(lat));
    @(negedge clk);
    check({name, " handoff"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
  endtask

  logic [31:0] exp_q[$];
  int  acc_cnt  = 0;
  int  out_cnt  = 0;
  bit  prod_done = 1'b0;
  logic [3:0] op_list[11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hC, 4'hF};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.Operation = 4'h0;
    bus.SrcA      = '0;
    bus.SrcB      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset result", bus.ALUResult, 32'd0);
    check("reset zero", 32'(bus.Zero), 32'd1);

    add_vec(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1,  "add wrap");
    add_vec(4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1,  "sub zero");
    add_vec(4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1,  "sub borrow");
    add_vec(4'b0111, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 32, "sra 31");
    add_vec(4'b0101, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 32, "srl 31");
    add_vec(4'b0100, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1,  "sll amt0");
    add_vec(4'b0100, 32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 5,  "sll 4");
    add_vec(4'b0111, 32'h7FFF_FFFF, 32'h0000_0004, 32'h07FF_FFFF, 5,  "sra pos");
    add_vec(4'b0101, 32'hF000_0000, 32'hFFFF_FFE4, 32'h0F00_0000, 5,  "srl upper b");
    add_vec(4'b1100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1,  "slt neg");
    add_vec(4'b1100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1,  "slt pos");
    add_vec(4'b1000, 32'h0000_1234, 32'h0000_1234, 32'h0000_0001, 1,  "eq same");
    add_vec(4'b1000, 32'h0000_1234, 32'h0000_1235, 32'h0000_0000, 1,  "eq diff");
    add_vec(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1,  "undef op");
    add_vec(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1,  "and");
    add_vec(4'b0001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1,  "or");
    add_vec(4'b0011, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1,  "xor");

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

    // Backpressure: result must hold and in_ready stay low while out_ready is low.
    @(negedge clk);
    bus.Operation = 4'b0010; bus.SrcA = 32'd3; bus.SrcB = 32'd4;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall out_valid", 32'(bus.out_valid), 32'd1);
      check("stall result", bus.ALUResult, 32'd7);
      check("stall in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("release out_valid", 32'(bus.out_valid), 32'd0);
    check("release in_ready", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of a 20-step shift discards the op.
    bus.Operation = 4'b0100; bus.SrcA = 32'd1; bus.SrcB = 32'd20; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midshift busy", {30'd0, bus.out_valid, bus.in_ready}, 32'b00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst result", bus.ALUResult, 32'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (bus.out_valid) seen++;
      end
      check("midrst no output", 32'(seen), 32'd0);
    end
    run_op(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1, "and after rst");

    // Random traffic with independent source and sink gaps.
    fork
      begin : producer
        for (int i = 0; i < 40; i++) begin
          int gap;
          int wcnt;
          logic [3:0] op;
          logic [31:0] a, b;
          gap = $urandom_range(0, 3);
          repeat (gap) @(negedge clk);
          op = op_list[$urandom_range(0, 10)];
          a  = $urandom;
          b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
          @(negedge clk);
          bus.Operation = op; bus.SrcA = a; bus.SrcB = b; bus.in_valid = 1'b1;
          wcnt = 0;
          while (!bus.in_ready && wcnt < 300) begin
            @(negedge clk);
            wcnt++;
          end
          if (!bus.in_ready) begin
            check("rand accept timeout", 32'd0, 32'd1);
            break;
          end
          exp_q.push_back(ref_model(op, a, b));
          acc_cnt++;
          @(negedge clk);
          bus.in_valid = 1'b0;
          bus.SrcA = $urandom;
          bus.SrcB = $urandom;
        end
        prod_done = 1'b1;
      end
      begin : consumer
        int cyc;
        cyc = 0;
        while (!(prod_done && exp_q.size() == 0) && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          bus.out_ready = ($urandom_range(0, 2) != 0);
          if (bus.out_valid && bus.out_ready) begin
            logic [31:0] e;
            check("rand pending", 32'(exp_q.size() > 0), 32'd1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check("rand result", bus.ALUResult, e);
            check("rand zero", 32'(bus.Zero), 32'(e == 32'd0));
            out_cnt++;
          end
        end
        bus.out_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    check("rand out_valid idle", 32'(bus.out_valid), 32'd0);
    check("rand count", 32'(out_cnt), 32'(acc_cnt));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
